// File: rtl/mem_pkg.sv
// mem_pkg: shared state encoding and constants for the data memory stage.
package mem_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} mem_state_t;
    localparam int DEFAULT_TIMEOUT = 16;
    localparam logic [7:0] BE_DWORD = 8'hFF;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane enables, store-data replication and zero-extended load-lane extraction.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic        byte_op_i,
    input  logic [2:0]  lane_i,
    input  logic [63:0] wdata_i,
    input  logic [63:0] rdata_i,
    output logic [7:0]  be_o,
    output logic [63:0] wdata_o,
    output logic [63:0] rdata_o
);
    assign be_o    = byte_op_i ? 8'b1 << lane_i : BE_DWORD;
    assign wdata_o = byte_op_i ? {8{wdata_i[7:0]}} : wdata_i;
    assign rdata_o = byte_op_i ? {56'h0, rdata_i[{lane_i, 3'b000} +: 8]} : rdata_i;
endmodule

// File: rtl/data_mem_stage.sv
// data_mem_stage: LDUR/STUR/LDURB/STURB against a req/ack data memory with timeout,
// producing a one-cycle write-back pulse; non-memory ops pass through in one cycle.
module data_mem_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [63:0] alu_result,
    input  logic [63:0] ReadData2,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        byte_op,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_be,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic        wb_valid,
    output logic [63:0] wb_data,
    output logic        err
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    mem_state_t    state_q;
    logic [CW-1:0] cnt_q;
    logic          byte_q;
    logic [2:0]    lane_q;
    logic          mem_op;
    logic          misalign;
    logic          al_byte;
    logic [2:0]    al_lane;
    logic [7:0]    al_be;
    logic [63:0]   al_wdata;
    logic [63:0]   al_rdata;
    logic [CW-1:0] cnt_inc;

    assign mem_op   = MemRead | MemWrite;
    assign misalign = !byte_op && (alu_result[2:0] != 3'd0);
    assign cnt_inc  = cnt_q + 1'b1;
    assign stall    = (state_q == ACCESS) || (state_q == IDLE && valid);
    // Lane select follows the live inputs at accept time, the captured lane while the access is open.
    assign al_byte  = (state_q == IDLE) ? byte_op : byte_q;
    assign al_lane  = (state_q == IDLE) ? alu_result[2:0] : lane_q;

    mem_lane_align u_align (
        .byte_op_i (al_byte),
        .lane_i    (al_lane),
        .wdata_i   (ReadData2),
        .rdata_i   (mem_rdata),
        .be_o      (al_be),
        .wdata_o   (al_wdata),
        .rdata_o   (al_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            byte_q    <= 1'b0;
            lane_q    <= 3'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 64'h0;
            mem_wdata <= 64'h0;
            mem_be    <= 8'h00;
            wb_valid  <= 1'b0;
            wb_data   <= 64'h0;
            err       <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            err      <= 1'b0;
            case (state_q)
                IDLE: if (valid) begin
                    if (mem_op && !misalign) begin
                        state_q   <= ACCESS;
                        cnt_q     <= '0;
                        mem_req   <= 1'b1;
                        mem_we    <= !MemRead;
                        mem_addr  <= {alu_result[63:3], 3'b000};
                        mem_wdata <= al_wdata;
                        mem_be    <= al_be;
                        byte_q    <= byte_op;
                        lane_q    <= alu_result[2:0];
                    end else begin
                        state_q  <= DONE;
                        wb_valid <= 1'b1;
                        err      <= mem_op;
                        wb_data  <= mem_op ? 64'h0 : alu_result;
                    end
                end
                ACCESS: begin
                    cnt_q <= cnt_inc;
                    // An ack arriving on the limit cycle still completes cleanly.
                    if (mem_ack || cnt_inc == LIMIT) begin
                        state_q  <= DONE;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        wb_valid <= 1'b1;
                        err      <= !mem_ack;
                        wb_data  <= (mem_ack && !mem_we) ? al_rdata : 64'h0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_stage.sv
// tb_data_mem_stage: directed and randomized checks of data_mem_stage against a transaction-level model.
module tb_data_mem_stage;
    logic        clk = 1'b0;
    logic        reset, valid, MemRead, MemWrite, byte_op, mem_ack;
    logic [63:0] alu_result, ReadData2, mem_rdata;
    logic        mem_req, mem_we, stall, wb_valid, err;
    logic [63:0] mem_addr, mem_wdata, wb_data;
    logic [7:0]  mem_be;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    data_mem_stage dut (
        .clk(clk), .reset(reset), .valid(valid), .alu_result(alu_result),
        .ReadData2(ReadData2), .MemRead(MemRead), .MemWrite(MemWrite), .byte_op(byte_op),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
        .wb_valid(wb_valid), .wb_data(wb_data), .err(err)
    );

    task automatic idle_inputs();
        valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; byte_op = 1'b0;
        alu_result = 64'h0; ReadData2 = 64'h0; mem_ack = 1'b0; mem_rdata = 64'h0;
    endtask

    // One transaction; ack_at is the ACCESS cycle (1-based) that carries mem_ack, outside 1..16 = never.
    task automatic run_op(input string name, input logic rd, input logic wr, input logic bop,
                          input logic [63:0] a, input logic [63:0] d, input logic [63:0] rdata,
                          input int ack_at, input logic noise);
        logic memop, mis, tmo, done, ewe;
        logic [7:0]  ebe;
        logic [63:0] ewd, erd, ewb, eaddr;
        memop = rd | wr;
        mis   = memop && !bop && (a[2:0] != 3'd0);
        tmo   = memop && !mis && (ack_at < 1 || ack_at > 16);
        ewe   = wr && !rd;
        ebe   = bop ? (8'h01 << a[2:0]) : 8'hFF;
        ewd   = bop ? {8{d[7:0]}} : d;
        erd   = bop ? ((rdata >> (8 * a[2:0])) & 64'hFF) : rdata;
        eaddr = a & ~64'h7;
        ewb   = !memop ? a : (mis || tmo || !rd) ? 64'h0 : erd;
        @(posedge clk); #1;
        valid = 1'b1; MemRead = rd; MemWrite = wr; byte_op = bop;
        alu_result = a; ReadData2 = d; mem_ack = noise; mem_rdata = {$urandom, $urandom};
        #1;
        vectors++;
        if (stall !== 1'b1) begin
            miscompares++;
            $display("FAIL %s accept_stall got %b exp 1", name, stall);
        end
        done = 1'b0;
        if (memop && !mis)
            for (int k = 1; k <= 16 && !done; k++) begin
                @(posedge clk); #1;
                mem_ack = 1'b0;
                vectors++;
                if ({mem_req, mem_we, stall, wb_valid, err, mem_be, mem_addr, mem_wdata} !==
                    {1'b1, ewe, 1'b1, 1'b0, 1'b0, ebe, eaddr, ewd}) begin
                    miscompares++;
                    $display("FAIL %s access_cyc%0d got req=%b we=%b stall=%b wbv=%b err=%b be=%h addr=%h wd=%h exp req=1 we=%b stall=1 wbv=0 err=0 be=%h addr=%h wd=%h",
                             name, k, mem_req, mem_we, stall, wb_valid, err, mem_be, mem_addr, mem_wdata, ewe, ebe, eaddr, ewd);
                end
                if (k == ack_at) begin
                    mem_ack = 1'b1; mem_rdata = rdata; done = 1'b1;
                end
            end
        @(posedge clk); #1;
        mem_ack = noise; mem_rdata = {$urandom, $urandom};
        vectors++;
        if ({wb_valid, err, mem_req, stall, wb_data} !== {1'b1, mis | tmo, 1'b0, 1'b0, ewb}) begin
            miscompares++;
            $display("FAIL %s done got wbv=%b err=%b req=%b stall=%b wb=%h exp wbv=1 err=%b req=0 stall=0 wb=%h",
                     name, wb_valid, err, mem_req, stall, wb_data, mis | tmo, ewb);
        end
        valid = 1'b0;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        vectors++;
        if ({wb_valid, err, mem_req, stall} !== 4'b0) begin
            miscompares++;
            $display("FAIL %s after_done got wbv=%b err=%b req=%b stall=%b exp all 0",
                     name, wb_valid, err, mem_req, stall);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({mem_req, mem_we, stall, wb_valid, err, mem_be, mem_addr, mem_wdata, wb_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_state got req=%b we=%b stall=%b wbv=%b err=%b be=%h addr=%h wd=%h wb=%h exp all 0",
                     mem_req, mem_we, stall, wb_valid, err, mem_be, mem_addr, mem_wdata, wb_data);
        end
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        @(posedge clk); #1;
        valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; byte_op = 1'b0; alu_result = 64'h40;
        @(posedge clk); #1;
        vectors++;
        if (mem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid pre_req got %b exp 1", mem_req);
        end
        reset = 1'b1; valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            vectors++;
            if ({mem_req, mem_we, stall, wb_valid, err, mem_be, mem_addr, mem_wdata, wb_data} !== '0) begin
                miscompares++;
                $display("FAIL rst_mid cyc%0d got req=%b stall=%b wbv=%b err=%b be=%h addr=%h wb=%h exp all 0",
                         c, mem_req, stall, wb_valid, err, mem_be, mem_addr, wb_data);
            end
        end
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 64'hDEAD_BEEF_0123_4567;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            vectors++;
            if ({mem_req, stall, wb_valid, err, wb_data} !== '0) begin
                miscompares++;
                $display("FAIL rst_mid late_ack%0d got req=%b stall=%b wbv=%b err=%b wb=%h exp all 0",
                         c, mem_req, stall, wb_valid, err, wb_data);
            end
        end
        idle_inputs();
    endtask

    task automatic test_passthrough();
        run_op("add_3ff", 1'b0, 1'b0, 1'b0, 64'h3FF, 64'h0, 64'h0, 0, 1'b0);
        run_op("add_odd", 1'b0, 1'b0, 1'b1, 64'hFFFF_0000_1234_5677, 64'h99, 64'h0, 0, 1'b1);
    endtask

    task automatic test_store();
        run_op("stur_10", 1'b0, 1'b1, 1'b0, 64'h10, 64'h155, 64'h0, 3, 1'b0);
        run_op("sturb_15", 1'b0, 1'b1, 1'b1, 64'h15, 64'h1234_56C3, 64'h0, 1, 1'b0);
    endtask

    task automatic test_load_byte();
        run_op("ldurb_13", 1'b1, 1'b0, 1'b1, 64'h13, 64'h0, 64'h0000_0000_AB00_0000, 2, 1'b0);
        run_op("ldurb_1f", 1'b1, 1'b0, 1'b1, 64'h1F, 64'h0, 64'hF1FF_FFFF_FFFF_FFFF, 1, 1'b0);
        run_op("ldur_rw", 1'b1, 1'b1, 1'b0, 64'h28, 64'h77, 64'h0123_4567_89AB_CDEF, 5, 1'b0);
    endtask

    task automatic test_misaligned();
        run_op("ldur_0c", 1'b1, 1'b0, 1'b0, 64'h0C, 64'h0, 64'h0, 1, 1'b0);
        run_op("stur_01", 1'b0, 1'b1, 1'b0, 64'h01, 64'h55, 64'h0, 1, 1'b1);
    endtask

    task automatic test_timeout();
        run_op("ldur_tmo", 1'b1, 1'b0, 1'b0, 64'h20, 64'h0, 64'h0, 0, 1'b0);
        run_op("ack_at_limit", 1'b1, 1'b0, 1'b0, 64'h30, 64'h0, 64'hCAFE_F00D_0000_0001, 16, 1'b0);
        run_op("ack_after_limit", 1'b0, 1'b1, 1'b1, 64'h33, 64'hEE, 64'h0, 17, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [63:0] a;
            a = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) a[2:0] = 3'd0;
            run_op("rand", 1'($urandom), 1'($urandom), 1'($urandom), a, {$urandom, $urandom},
                   {$urandom, $urandom}, int'($urandom_range(0, 17)), 1'($urandom));
        end
    endtask

    task automatic test_back_to_back();
        run_op("b2b_ld", 1'b1, 1'b0, 1'b0, 64'h100, 64'h0, 64'h1111_2222_3333_4444, 1, 1'b0);
        run_op("b2b_add", 1'b0, 1'b0, 1'b0, 64'h5A5A, 64'h0, 64'h0, 0, 1'b0);
        run_op("b2b_stb", 1'b0, 1'b1, 1'b1, 64'h107, 64'hAB, 64'h0, 1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_store();
        test_load_byte();
        test_misaligned();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
